// File: rtl/accum.sv
// accum: sums LEN accepted signed samples into one WIDTH-bit result (wrap, or clamp with ACCUM_SATURATE_EN).
// Latency: result registered on the LEN-th accept edge; handoff costs one idle intake cycle.
// Backpressure: in_ready is a pure state decode, low while a result waits for f_ready.
module accum #(
    parameter int WIDTH = 16,
    parameter int LEN   = 4,
    localparam int CW   = $clog2(LEN + 1),
    localparam int AW   = WIDTH + $clog2(LEN) + 1
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic                    clear,
    output logic signed [WIDTH-1:0] f,
    output logic                    f_valid,
    input  logic                    f_ready,
`ifdef ACCUM_SATURATE_EN
    output logic                    sat_flag,
`endif
    output logic [CW-1:0]           count
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t                  state, state_nxt;
    logic signed [AW-1:0]    acc, acc_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic signed [WIDTH-1:0] f_nxt;
    logic                    fv_nxt;
    logic                    accept;
    logic                    last;
    logic signed [AW-1:0]    sum;
    logic signed [WIDTH-1:0] f_conv;

`ifdef ACCUM_SATURATE_EN
    localparam logic signed [AW-1:0] F_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] F_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    logic sat_nxt;
    logic sat_hit;

    always_comb begin
        sat_hit = 1'b1;
        if (sum > F_MAX)      f_conv = F_MAX[WIDTH-1:0];
        else if (sum < F_MIN) f_conv = F_MIN[WIDTH-1:0];
        else begin
            f_conv  = sum[WIDTH-1:0];
            sat_hit = 1'b0;
        end
    end
`else
    assign f_conv = sum[WIDTH-1:0];
`endif

    assign in_ready = (state != S_HOLD);
    assign accept   = in_valid & in_ready;
    assign last     = (cnt == CW'(LEN - 1));
    // The first sample of a group starts from zero rather than the stale accumulator.
    assign sum      = ((state == S_IDLE) ? '0 : acc) + {{(AW-WIDTH){a[WIDTH-1]}}, a};
    assign count    = cnt;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        f_nxt     = f;
        fv_nxt    = f_valid;
`ifdef ACCUM_SATURATE_EN
        sat_nxt   = sat_flag;
`endif
        if (clear) begin
            state_nxt = S_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            fv_nxt    = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CW'(1);
                        if (last) begin
                            state_nxt = S_HOLD;
                            f_nxt     = f_conv;
                            fv_nxt    = 1'b1;
`ifdef ACCUM_SATURATE_EN
                            sat_nxt   = sat_hit;
`endif
                        end else begin
                            state_nxt = S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (f_valid && f_ready) begin
                        state_nxt = S_IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        fv_nxt    = 1'b0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            f        <= '0;
            f_valid  <= 1'b0;
`ifdef ACCUM_SATURATE_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            f        <= f_nxt;
            f_valid  <= fv_nxt;
`ifdef ACCUM_SATURATE_EN
            sat_flag <= sat_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_accum.sv
// Bench for accum: directed literal cases plus randomized traffic against a group-sum reference model.
module tb_accum;
    localparam int WIDTH = 16;
    localparam int LEN   = 4;
    localparam int CW    = $clog2(LEN + 1);

    logic                    clk = 1'b0;
    logic                    reset_l = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    clear = 1'b0;
    logic                    f_ready = 1'b1;
    logic signed [WIDTH-1:0] a = '0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] f;
    logic                    f_valid;
    logic [CW-1:0]           count;
`ifdef ACCUM_SATURATE_EN
    logic                    sat_flag;
`endif

    int tests = 0;
    int fails = 0;

    accum #(.WIDTH(WIDTH), .LEN(LEN)) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .clear    (clear),
        .f        (f),
        .f_valid  (f_valid),
        .f_ready  (f_ready),
`ifdef ACCUM_SATURATE_EN
        .sat_flag (sat_flag),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a group is just a running integer sum of accepted samples.
    bit          m_hold = 0;
    int          m_cnt  = 0;
    longint      m_sum  = 0;
    logic [15:0] m_f    = '0;
    bit          m_fv   = 0;
    bit          m_sat  = 0;

    function automatic logic [15:0] convert(input longint s);
        longint t;
        t = s;
`ifdef ACCUM_SATURATE_EN
        if (t > 32767)  t = 32767;
        if (t < -32768) t = -32768;
`endif
        return t[15:0];
    endfunction

    always @(posedge clk) begin
        if (reset_l) begin
            if (clear) begin
                m_hold = 0; m_cnt = 0; m_sum = 0; m_fv = 0;
            end else if (m_hold) begin
                if (f_ready) begin
                    m_hold = 0; m_cnt = 0; m_sum = 0; m_fv = 0;
                end
            end else if (in_valid) begin
                m_sum = m_sum + longint'(a);
                m_cnt = m_cnt + 1;
                if (m_cnt == LEN) begin
                    m_hold = 1;
                    m_fv   = 1;
                    m_f    = convert(m_sum);
                    m_sat  = (m_sum > 32767) || (m_sum < -32768);
                end
            end
        end
    end

    always @(negedge reset_l) begin
        m_hold = 0; m_cnt = 0; m_sum = 0; m_fv = 0; m_f = '0; m_sat = 0;
    end

    always @(negedge clk) begin
        if (reset_l) begin
            check("f_valid", {31'd0, f_valid}, {31'd0, m_fv});
            check("f", {16'd0, f}, {16'd0, m_f});
            check("count", 32'(count), 32'(m_cnt));
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_hold});
`ifdef ACCUM_SATURATE_EN
            if (m_fv) check("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        bit done;
        bit r;
        done = 0;
        in_valid = 1'b1;
        a = v;
        for (int i = 0; i < 50; i++) begin
            r = in_ready;
            step();
            if (r) begin
                done = 1;
                break;
            end
        end
        in_valid = 1'b0;
        check("push_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_fv(input string name);
        for (int i = 0; i < 20 && !f_valid; i++) step();
        check(name, {31'd0, f_valid}, 32'd1);
    endtask

    task automatic group4(input logic [15:0] v, input logic [15:0] exp, input string name);
        for (int i = 0; i < 4; i++) push(v);
        wait_fv({name, "_valid"});
        check(name, {16'd0, f}, {16'd0, exp});
    endtask

    logic [15:0] gap_s [4];

    initial begin
        #1 reset_l = 1'b0;
        #11;
        check("reset_f_valid", {31'd0, f_valid}, 32'd0);
        check("reset_f", {16'd0, f}, 32'd0);
        check("reset_count", 32'(count), 32'd0);
        reset_l = 1'b1;
        step();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic sum, back-to-back
        f_ready = 1'b1;
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        check("basic_valid", {31'd0, f_valid}, 32'd1);
        check("basic_f", {16'd0, f}, 32'h000A);
        check("basic_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("basic_valid_one_cycle", {31'd0, f_valid}, 32'd0);
        check("basic_f_kept", {16'd0, f}, 32'h000A);

        // Backpressure
        f_ready = 1'b0;
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_f", {16'd0, f}, 32'h000A);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, f_valid}, 32'd1);
            step();
        end
        f_ready = 1'b1;
        step();
        check("bp_valid_drop", {31'd0, f_valid}, 32'd0);
        push(16'd7);
        check("bp_next_accept_count", 32'(count), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", 32'(count), 32'd0);

        // Gapped input
        gap_s[0] = 16'hFFFD; gap_s[1] = 16'h0007; gap_s[2] = 16'hFFFF; gap_s[3] = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            push(gap_s[i]);
            check("gap_count", 32'(count), 32'(i + 1));
            if (i < 3) begin
                step(); step();
                check("gap_count_idle", 32'(count), 32'(i + 1));
            end
        end
        check("gap_valid", {31'd0, f_valid}, 32'd1);
        check("gap_f", {16'd0, f}, 32'h0005);
        step();

`ifdef ACCUM_SATURATE_EN
        group4(16'h7000, 16'h7FFF, "ovf_f");
        check("ovf_sat", {31'd0, sat_flag}, 32'd1);
        step();
        group4(16'h9000, 16'h8000, "unf_f");
        check("unf_sat", {31'd0, sat_flag}, 32'd1);
        step();
`else
        group4(16'h7000, 16'hC000, "ovf_f");
        step();
        group4(16'h9000, 16'h4000, "unf_f");
        step();
`endif

        // Abort: the sample presented with clear is discarded
        push(16'd9); push(16'd9);
        clear = 1'b1; in_valid = 1'b1; a = 16'd9;
        step();
        clear = 1'b0; in_valid = 1'b0;
        group4(16'd5, 16'h0014, "abort_f");
        step();

        // Reset while holding a result
        f_ready = 1'b0;
        group4(16'd3, 16'h000C, "hold_f");
        #3 reset_l = 1'b0;
        #1;
        check("rst_hold_valid", {31'd0, f_valid}, 32'd0);
        check("rst_hold_f", {16'd0, f}, 32'd0);
        check("rst_hold_count", 32'(count), 32'd0);
        #2 reset_l = 1'b1;
        f_ready = 1'b1;
        step();

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom % 4) != 0;
            a        = (($urandom % 3) == 0) ? 16'(16'h7000 + ($urandom % 16'h1000)) : 16'($urandom);
            f_ready  = ($urandom % 3) != 0;
            clear    = ($urandom % 40) == 0;
            step();
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/accum.md
Name: accum

Overview:
- Streaming fixed-point accumulator sitting directly downstream of the pipelined add/sub stages (e.g. sub4 / add4 outputs).
- Sums LEN consecutive accepted samples into one result, such as a dot-product or row-reduction term.
- Presents the result on a valid/ready output handshake.
- Backpressure from the consumer stalls sample intake.

Parameters:
- LEN, 4, number of samples per result; legal range 1..65535.
- g.WIDTH (from fixedp bundle), n/a, sample and result width in two's-complement fixed point; the binary point is irrelevant to this block.

Ports:
- g.clk  input  1  clock (fixedp bundle)
- g.reset_l  input  1  asynchronous active-low reset (fixedp bundle)
- in_valid  input  1  sample a is valid this cycle
- in_ready  output  1  block can accept a sample this cycle
- a  input  g.WIDTH  signed sample
- clear  input  1  synchronous abort of current group
- f  output  g.WIDTH  signed result
- f_valid  output  1  result valid
- f_ready  input  1  consumer takes result
- count  output  clog2(LEN+1)  samples accepted in current group

Behaviour:
- Reset (g.reset_l low, asynchronous):
  - state=IDLE; acc=0, count=0, f=0, f_valid=0.
  - in_ready=1 once reset is released.
- Accumulator acc:
  - Width is g.WIDTH+clog2(LEN)+1, signed.
  - Each sample is sign-extended; no internal overflow is possible.
- Accept: accept = in_valid & in_ready.
  - in_ready is a decode of state only: 1 in IDLE/ACCUM, 0 in HOLD.
  - There is no combinational path from f_ready to in_ready.
- States:
  - IDLE:
    - accept -> acc=a, count=1.
    - Go to ACCUM, or to HOLD if LEN==1.
  - ACCUM:
    - accept -> acc=acc+a, count=count+1.
    - On the LEN-th accept, go to HOLD.
    - No accept -> hold all state; gaps in in_valid are allowed.
  - HOLD:
    - f and f_valid are registered on the edge of the LEN-th accept, so f_valid=1 one cycle after that sample is presented.
    - f and f_valid stay stable while f_ready=0.
    - f_valid & f_ready -> f_valid=0 next cycle, count=0, acc=0, state IDLE.
    - f keeps its last value after f_valid drops.
- Throughput: at most LEN samples per LEN+1 cycles; the handoff costs one cycle.
- Output conversion when loading f: take the low g.WIDTH bits of the final sum (wrap).
- clear:
  - Synchronous; highest priority over accept and the output handshake.
  - Next cycle: state=IDLE, acc=0, count=0, f_valid=0; f is unchanged.
  - A sample presented in the same cycle as clear is discarded.
- Reset mid-operation: async reset in any state immediately forces f_valid=0, f=0, count=0.
- count is a registered copy of the internal sample counter and reads LEN while in HOLD.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined: the final sum is clamped to [-2^(g.WIDTH-1), 2^(g.WIDTH-1)-1] when loading f.
  - Adds output sat_flag (1 bit), registered alongside f and valid with f_valid; it is 1 when clamping occurred.
  - sat_flag resets to 0.
- Undefined: f wraps (low g.WIDTH bits); no sat_flag port exists.
- Cycle timing is identical in both builds.

Test Plan:
- Basic sum (WIDTH=16, LEN=4):
  - Stimulus: accept 1,2,3,4 back-to-back, f_ready=1.
  - Response: f=0x000A, f_valid=1 for exactly 1 cycle, one cycle after sample 4; in_ready=0 that cycle.
- Backpressure:
  - Stimulus: same group with f_ready=0 for 5 cycles, then 1.
  - Response: f=0x000A stable and in_ready=0 for all 5 cycles; f_valid drops the cycle after f_ready rises; next sample is accepted the following cycle.
- Gapped input:
  - Stimulus: samples -3,7,-1,2 (0xFFFD,0x0007,0xFFFF,0x0002) with 2 idle cycles between each.
  - Response: f=0x0005; count steps 1,2,3,4 only on accepts.
- Overflow, 4×0x7000:
  - Without ACCUM_SATURATE_EN: f=0xC000.
  - With it: f=0x7FFF, sat_flag=1.
- Underflow, 4×0x9000:
  - Without ACCUM_SATURATE_EN: f=0x4000.
  - With it: f=0x8000, sat_flag=1.
- Abort and reset:
  - Stimulus: accept 9,9, then clear (with in_valid=1, a=9 in the same cycle), then accept 5,5,5,5.
  - Response: f=0x0014.
  - Separately: assert g.reset_l=0 mid-HOLD -> f_valid=0 and f=0 immediately, before the next g.clk edge.
